spi_adc_scanner: RTL and testbench
==================================

// Module: spi_adc_scanner
// PURPOSE
//  Round-robin SPI master for a multi-channel serial ADC; generalised, multi-channel successor to the single-channel SPI reader.
//  Scans NUM_CH channels and returns one DATA_W-bit sample per frame with channel tag and valid strobe.
//  Keeps per-channel hysteresis threshold flags for LED/indicator logic downstream.
//  Sits between the ADC pins and the display/indicator logic, in the prescaled clock domain.
// PARAMETERS
//  DATA_W   12  sample width, bits (1..16)
//  NUM_CH   4   channels scanned (1..8); CH_W = max(1,clog2(NUM_CH))
//  CLK_DIV  2   clk cycles per SCK half-period (>=1)
//  GAP_CYC  4   clk cycles CS_n held high between frames (>=1)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        synchronous reset, active low
//  i_enable     in   1        1 = scan continuously; sampled in IDLE and at end of GAP
//  i_miso       in   1        ADC serial data out
//  i_thresh_hi  in   DATA_W   set level for o_above (unsigned)
//  i_thresh_lo  in   DATA_W   clear level for o_above (unsigned)
//  o_mosi       out  1        command bits to ADC
//  o_sck        out  1        SPI clock, idle low (mode 0)
//  o_cs_n       out  1        chip select, active low
//  o_data       out  DATA_W   last captured sample
//  o_ch         out  CH_W     channel of o_data
//  o_valid      out  1        1-cycle strobe: o_data/o_ch new
//  o_above      out  NUM_CH   per-channel hysteresis flag
//  o_busy       out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, ch ptr 0, o_cs_n=1, o_sck=0, o_mosi=0,
//   o_data=0, o_ch=0, o_valid=0, o_above=0, o_busy=0. Reset mid-frame aborts: no o_valid, CS_n high next cycle.
//  Frame = FRAME=2+CH_W+DATA_W bits: MOSI bit0 start '1', then CH_W address bits MSB first,
//   then one null bit '0'; MISO data is the last DATA_W bits, MSB first; MOSI=0 during data bits.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (SETUP | IDLE).
//   IDLE: i_enable=1 -> SETUP next cycle with ch ptr = 0.
//   SETUP: CLK_DIV cycles; o_cs_n=0, o_sck=0, o_mosi=start bit.
//   SHIFT: per bit, SCK high CLK_DIV cycles then low CLK_DIV cycles (2*CLK_DIV*FRAME total).
//    MISO registered in the cycle SCK is driven 0->1; MOSI advances in the cycle SCK is driven 1->0.
//   HOLD: CLK_DIV cycles, CS_n low, SCK low.
//   Exit HOLD: o_cs_n=1, o_valid=1, o_data=shift reg, o_ch=ptr, all in the same cycle.
//   GAP: GAP_CYC cycles CS_n high; at its last cycle ptr wraps NUM_CH-1 -> 0 else +1;
//    i_enable=1 -> SETUP, else IDLE (next enable restarts at ch 0).
//  CS_n low duration = CLK_DIV*(2*FRAME+2) cycles; frame period = that + GAP_CYC.
//  i_enable dropped mid-frame: frame completes with o_valid, then IDLE.
//  o_above[ch] updated in the o_valid cycle, visible next cycle:
//   data>=hi -> 1; else data<=lo -> 0; else hold. Set wins if lo>=hi. Other channels untouched.
//  Threshold inputs sampled only in the o_valid cycle; changes otherwise have no effect.
// TESTING
//  Defaults, MISO model returns 12'hA5C on ch2 -> o_valid with o_ch=2, o_data=12'hA5C; CS_n low exactly 68 cycles.
//  MOSI capture on frame for ch3 -> bit sequence 1,1,1,0 then twelve 0s; SCK high/low 2 cycles each, 16 pulses.
//  Continuous enable, 9 frames -> o_ch sequence 0,1,2,3,0,1,2,3,0; CS_n high 4 cycles between frames.
//  hi=800, lo=200 on ch1: samples 500,900,500,150,500 -> o_above[1] = 0,1,1,0,0.
//  Drop i_enable mid-SHIFT -> frame completes, one o_valid, then IDLE, o_busy=0, CS_n stays 1.
//  rst_n=0 for 1 cycle mid-SHIFT -> next cycle CS_n=1, SCK=0, o_above=0, no o_valid; re-enable starts ch 0.

Source files
------------

// File: rtl/spi_adc_scanner.sv
// Round-robin SPI (mode 0) master for a multi-channel serial ADC.
// Returns one tagged sample per frame and keeps a hysteresis flag per channel.
module spi_adc_scanner #(
   parameter int DATA_W  = 12,
   parameter int NUM_CH  = 4,
   parameter int CLK_DIV = 2,
   parameter int GAP_CYC = 4,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic              i_miso,
   input  logic [DATA_W-1:0] i_thresh_hi,
   input  logic [DATA_W-1:0] i_thresh_lo,
   output logic              o_mosi,
   output logic              o_sck,
   output logic              o_cs_n,
   output logic [DATA_W-1:0] o_data,
   output logic [CH_W-1:0]   o_ch,
   output logic              o_valid,
   output logic [NUM_CH-1:0] o_above,
   output logic              o_busy
);
   localparam int FRAME   = 2 + CH_W + DATA_W;
   localparam int BIT_W   = $clog2(FRAME + 1);
   localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME);
   localparam logic [CNT_W-1:0] DIV_END  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic [2:0]        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [BIT_W-1:0]  bit_reg;
   logic [CH_W-1:0]   ptr_reg;
   logic [CH_W-1:0]   ptr_next;
   logic [FRAME-1:0]  tx_reg;
   logic [DATA_W-1:0] rx_reg;
   logic              sck_reg;
   logic              cs_n_reg;
   logic              valid_reg;
   logic [DATA_W-1:0] data_reg;
   logic [CH_W-1:0]   ch_reg;
   logic [NUM_CH-1:0] above_reg;
   logic [NUM_CH-1:0] above_next;
   logic              div_done;
   logic              gap_done;

   // Command word, sent MSB first: start '1', channel address, null '0', then zeros.
   function automatic logic [FRAME-1:0] cmd_word(input logic [CH_W-1:0] p);
      return {1'b1, p, 1'b0, {DATA_W{1'b0}}};
   endfunction

   assign ptr_next = (ptr_reg == CH_LAST) ? '0 : ptr_reg + CH_W'(1);
   assign div_done = (cnt_reg == DIV_END);
   assign gap_done = (cnt_reg == GAP_END);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         ptr_reg   <= '0;
         tx_reg    <= '0;
         rx_reg    <= '0;
         sck_reg   <= 1'b0;
         cs_n_reg  <= 1'b1;
         valid_reg <= 1'b0;
         data_reg  <= '0;
         ch_reg    <= '0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (i_enable) begin
                  state_reg <= S_SETUP;
                  cnt_reg   <= '0;
                  ptr_reg   <= '0;
                  tx_reg    <= cmd_word('0);
                  cs_n_reg  <= 1'b0;
               end
            end
            S_SETUP: begin
               if (div_done) begin
                  state_reg <= S_SHIFT;
                  cnt_reg   <= '0;
                  bit_reg   <= '0;
                  sck_reg   <= 1'b1;
                  rx_reg    <= DATA_W'({rx_reg, i_miso});
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_SHIFT: begin
               if (!div_done) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end else begin
                  cnt_reg <= '0;
                  // MISO is captured as SCK rises, MOSI advances as SCK falls.
                  if (sck_reg) begin
                     sck_reg <= 1'b0;
                     tx_reg  <= tx_reg << 1;
                     bit_reg <= bit_reg + BIT_W'(1);
                  end else if (bit_reg == LAST_BIT) begin
                     state_reg <= S_HOLD;
                  end else begin
                     sck_reg <= 1'b1;
                     rx_reg  <= DATA_W'({rx_reg, i_miso});
                  end
               end
            end
            S_HOLD: begin
               if (div_done) begin
                  state_reg <= S_GAP;
                  cnt_reg   <= '0;
                  cs_n_reg  <= 1'b1;
                  valid_reg <= 1'b1;
                  data_reg  <= rx_reg;
                  ch_reg    <= ptr_reg;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_GAP: begin
               if (gap_done) begin
                  cnt_reg <= '0;
                  ptr_reg <= ptr_next;
                  if (i_enable) begin
                     state_reg <= S_SETUP;
                     tx_reg    <= cmd_word(ptr_next);
                     cs_n_reg  <= 1'b0;
                  end else begin
                     state_reg <= S_IDLE;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Hysteresis: set at/above hi, clear at/below lo, otherwise hold; set has priority.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
         logic hit;
         assign hit = valid_reg && (ch_reg == CH_W'(gi));
         assign above_next[gi] = !hit                        ? above_reg[gi] :
                                 (data_reg >= i_thresh_hi)   ? 1'b1 :
                                 (data_reg <= i_thresh_lo)   ? 1'b0 : above_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) above_reg <= '0;
      else        above_reg <= above_next;
   end

   assign o_mosi  = tx_reg[FRAME-1];
   assign o_sck   = sck_reg;
   assign o_cs_n  = cs_n_reg;
   assign o_data  = data_reg;
   assign o_ch    = ch_reg;
   assign o_valid = valid_reg;
   assign o_above = above_reg;
   assign o_busy  = (state_reg != S_IDLE);
endmodule

// File: tb/tb_spi_adc_scanner.sv
// Self-checking bench for spi_adc_scanner: frame-level reference model compared on every cycle,
// directed literal checks and a randomized phase.
module tb_spi_adc_scanner;
   localparam int DW     = 12;
   localparam int NCH    = 4;
   localparam int CD     = 2;
   localparam int GC     = 4;
   localparam int CHW    = 2;
   localparam int FR     = 2 + CHW + DW;
   localparam int LOWLEN = CD * (2 * FR + 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_enable = 1'b0;
   logic          i_miso = 1'b0;
   logic [DW-1:0] i_thresh_hi = 12'hFFF;
   logic [DW-1:0] i_thresh_lo = 12'h000;
   logic          o_mosi, o_sck, o_cs_n, o_valid, o_busy;
   logic [DW-1:0] o_data;
   logic [CHW-1:0] o_ch;
   logic [NCH-1:0] o_above;

   always #5 clk = ~clk;

   spi_adc_scanner #(.DATA_W(DW), .NUM_CH(NCH), .CLK_DIV(CD), .GAP_CYC(GC)) dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_miso(i_miso),
      .i_thresh_hi(i_thresh_hi), .i_thresh_lo(i_thresh_lo),
      .o_mosi(o_mosi), .o_sck(o_sck), .o_cs_n(o_cs_n), .o_data(o_data),
      .o_ch(o_ch), .o_valid(o_valid), .o_above(o_above), .o_busy(o_busy)
   );

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
   endtask

   // ---------------- reference model (frame timeline: idle / frame / gap) ----------------
   int            m_mode = 0;      // 0 idle, 1 CS low, 2 CS high after a frame
   int            m_idx = 0;       // cycle index inside the current mode
   int            m_ch = 0;
   logic [DW-1:0] m_sample = '0;
   logic [15:0]   m_junk = '0;
   logic [DW-1:0] m_data = '0;
   int            m_och = 0;
   logic [NCH-1:0] m_above = '0;
   bit            rand_samples = 0;
   logic [DW-1:0] adc_val [NCH];

   function automatic logic cmd_bit(input int b, input int ch);
      if (b == 0) return 1'b1;
      if (b <= CHW) return 1'((ch >> (CHW - b)) & 1);
      return 1'b0;
   endfunction

   task automatic start_frame(input int ch);
      m_mode = 1;
      m_idx  = 0;
      m_ch   = ch;
      m_junk = 16'($urandom);
      if (rand_samples) begin
         case ($urandom_range(0, 4))
            0: m_sample = i_thresh_hi;
            1: m_sample = i_thresh_lo;
            2: m_sample = '0;
            3: m_sample = '1;
            default: m_sample = DW'($urandom);
         endcase
      end else begin
         m_sample = adc_val[ch];
      end
   endtask

   logic [63:0] exp_v, act_v;
   logic        e_sck, e_mosi;
   int          mj;

   always @(negedge clk) begin
      // 1) compare every output against the model's view of this cycle
      e_sck  = (m_mode == 1) && (m_idx >= CD) && (m_idx < CD * (2 * FR + 1)) &&
               (((m_idx - CD) % (2 * CD)) < CD);
      e_mosi = (m_mode == 1) ? cmd_bit(m_idx / (2 * CD), m_ch) : 1'b0;
      exp_v  = {41'd0, (m_mode != 1), e_sck, e_mosi, (m_mode != 0), (m_mode == 2 && m_idx == 0),
                2'(m_och), m_data, m_above};
      act_v  = {41'd0, o_cs_n, o_sck, o_mosi, o_busy, o_valid, o_ch, o_data, o_above};
      chk("pins{cs_n,sck,mosi,busy,valid,ch,data,above}", act_v, exp_v);
      // 2) ADC side: present the bit the master will sample at its next SCK rise
      if (m_mode == 1) begin
         mj = (m_idx + CD) / (2 * CD);
         if (mj < 2 + CHW) i_miso = m_junk[mj];
         else if (mj < FR) i_miso = m_sample[DW - 1 - (mj - 2 - CHW)];
         else i_miso = 1'($urandom_range(0, 1));
      end else begin
         i_miso = 1'($urandom_range(0, 1));
      end
      // 3) advance the model to the next cycle
      if (!rst_n) begin
         m_mode = 0; m_idx = 0; m_data = '0; m_och = 0; m_above = '0;
      end else begin
         case (m_mode)
            0: if (i_enable) start_frame(0);
            1: begin
               if (m_idx == LOWLEN - 1) begin
                  m_mode = 2; m_idx = 0; m_data = m_sample; m_och = m_ch;
               end else m_idx++;
            end
            default: begin
               if (m_idx == 0) begin
                  if (m_data >= i_thresh_hi) m_above[m_och] = 1'b1;
                  else if (m_data <= i_thresh_lo) m_above[m_och] = 1'b0;
               end
               if (m_idx == GC - 1) begin
                  if (i_enable) start_frame((m_ch + 1) % NCH);
                  else m_mode = 0;
               end else m_idx++;
            end
         endcase
      end
   end

   // ---------------- pin measurements for literal checks ----------------
   int          low_run = 0, last_low = 0, high_run = 0, last_high = 0, pulses = 0;
   logic [15:0] mosi_cap = '0;
   logic        prev_cs = 1'b1, prev_sck = 1'b0;

   always @(negedge clk) begin
      if (o_cs_n === 1'b0) begin
         if (prev_cs) begin last_high = high_run; low_run = 0; mosi_cap = '0; pulses = 0; end
         low_run++;
         if (o_sck === 1'b1 && !prev_sck) begin mosi_cap = {mosi_cap[14:0], o_mosi}; pulses++; end
      end else begin
         if (!prev_cs) begin last_low = low_run; high_run = 0; end
         high_run++;
      end
      prev_cs  = o_cs_n;
      prev_sck = o_sck;
   end

   // ---------------- bounded waits ----------------
   task automatic wait_valid(input string name);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (o_valid === 1'b1) begin ok = 1; break; end
      end
      if (!ok) chk({name, "_valid_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (o_busy === 1'b0) begin ok = 1; break; end
      end
      if (!ok) chk({name, "_idle_timeout"}, 0, 1);
   endtask

   task automatic wait_sck(input string name);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (o_sck === 1'b1) begin ok = 1; break; end
      end
      if (!ok) chk({name, "_sck_timeout"}, 0, 1);
   endtask

   // ---------------- stimulus ----------------
   int   chsq [9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
   int   samp [5]  = '{500, 900, 500, 150, 500};
   logic ab_exp [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   int   nval, ncs;
   bit   found;

   initial begin
      adc_val[0] = 12'h111; adc_val[1] = 12'h222; adc_val[2] = 12'hA5C; adc_val[3] = 12'h333;
      @(posedge clk); @(negedge clk);
      chk("reset_cs_n", o_cs_n, 1);
      chk("reset_sck", o_sck, 0);
      chk("reset_busy_valid", {o_busy, o_valid}, 0);
      chk("reset_data_above", {o_data, o_above}, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // single sample on channel 2 after starting from idle
      @(posedge clk); #1 i_enable = 1'b1;
      repeat (3) wait_valid("a");
      #1;
      chk("a_ch", o_ch, 2);
      chk("a_data", o_data, 12'hA5C);
      chk("a_cs_low_cycles", last_low, 68);

      // command bits on channel 3
      wait_valid("b");
      #1;
      chk("b_ch", o_ch, 3);
      chk("b_mosi_bits", mosi_cap, 16'hE000);
      chk("b_sck_pulses", pulses, 16);
      chk("b_gap_cycles", last_high, GC);

      // continuous scan of 9 frames from idle
      @(posedge clk); #1 i_enable = 1'b0;
      wait_idle("c");
      @(posedge clk); #1 i_enable = 1'b1;
      for (int k = 0; k < 9; k++) begin
         wait_valid("c");
         chk($sformatf("c_ch_seq%0d", k), o_ch, chsq[k]);
      end
      #1 chk("c_gap_cycles", last_high, GC);

      // enable dropped mid-SHIFT: frame completes, then idle
      wait_sck("f");
      @(posedge clk); #1 i_enable = 1'b0;
      wait_valid("f");
      nval = 0; ncs = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_valid === 1'b1) nval++;
         if (o_cs_n !== 1'b1) ncs++;
      end
      chk("f_extra_valid", nval, 0);
      chk("f_cs_low_after", ncs, 0);
      chk("f_busy", o_busy, 0);

      // reset for one cycle mid-SHIFT
      @(posedge clk); #1 i_thresh_hi = '0; i_thresh_lo = '0; i_enable = 1'b1;
      wait_valid("e");
      wait_valid("e");
      @(negedge clk);
      chk("e_above_before", o_above, 4'b0011);
      wait_sck("e");
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("e_cs_n", o_cs_n, 1);
      chk("e_sck", o_sck, 0);
      chk("e_above", o_above, 0);
      chk("e_valid", o_valid, 0);
      wait_valid("e");
      chk("e_restart_ch", o_ch, 0);
      @(posedge clk); #1 i_enable = 1'b0;
      wait_idle("e");

      // hysteresis on channel 1
      @(posedge clk); #1
      i_thresh_hi = 12'd800; i_thresh_lo = 12'd200; adc_val[1] = DW'(samp[0]); i_enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         found = 0;
         for (int v = 0; v < 5 && !found; v++) begin
            wait_valid("d");
            if (o_ch === 2'd1) found = 1;
         end
         chk($sformatf("d_found%0d", k), found, 1);
         @(posedge clk); #1 if (k < 4) adc_val[1] = DW'(samp[k + 1]);
         @(negedge clk);
         chk($sformatf("d_above1_%0d", k), o_above[1], ab_exp[k]);
      end

      // randomized phase: enable toggles, threshold churn, occasional reset
      rand_samples = 1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 199) == 0) i_enable = !i_enable;
         if ($urandom_range(0, 15) == 0) begin
            i_thresh_hi = DW'($urandom);
            i_thresh_lo = DW'($urandom);
         end
         rst_n = ($urandom_range(0, 1499) != 0);
      end
      @(posedge clk); #1 rst_n = 1'b1; i_enable = 1'b0;
      wait_idle("r");
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
